// File: rtl/sequence_generator.sv
// Serial pattern transmitter: captures a PAT_W-bit pattern and shifts it out MSB-first,
// repeating reps+1 times with GAP idle cycles between. Define SEQ_GEN_PARITY_EN for a parity bit.
module sequence_generator #(
    parameter int unsigned PAT_W = 5,
    parameter int unsigned CNT_W = 4,
    parameter int unsigned GAP   = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [PAT_W-1:0] pattern,
    input  logic [CNT_W-1:0] reps,
    input  logic             abort,
    output logic             out,
    output logic             valid,
    output logic             busy,
    output logic             done
);

`ifdef SEQ_GEN_PARITY_EN
    localparam int unsigned SeqLen = PAT_W + 1;
`else
    localparam int unsigned SeqLen = PAT_W;
`endif
    localparam int unsigned BitW = $clog2(SeqLen + 1);
    localparam int unsigned GapW = $clog2(GAP + 2);

    typedef enum logic [1:0] {StIdle, StShift, StGap} state_e;

    state_e           state_q, state_d;
    logic [PAT_W-1:0] shreg_q, shreg_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic [BitW-1:0]  bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0] rep_q, rep_d;
    logic [GapW-1:0]  gap_q, gap_d;
    logic             out_q, out_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             next_bit;

`ifdef SEQ_GEN_PARITY_EN
    // Once all pattern bits are out, the trailing bit is the even parity of the captured copy.
    assign next_bit = (bit_cnt_q == BitW'(PAT_W)) ? ^pat_q : shreg_q[PAT_W-1];
`else
    assign next_bit = shreg_q[PAT_W-1];
`endif

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        pat_d     = pat_q;
        bit_cnt_d = bit_cnt_q;
        rep_d     = rep_q;
        gap_d     = gap_q;
        out_d     = 1'b0;
        valid_d   = 1'b0;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start && !abort) begin
                    state_d   = StShift;
                    pat_d     = pattern;
                    shreg_d   = pattern << 1;
                    rep_d     = reps;
                    bit_cnt_d = BitW'(1);
                    out_d     = pattern[PAT_W-1];
                    valid_d   = 1'b1;
                    busy_d    = 1'b1;
                end
            end
            StShift: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (bit_cnt_q != BitW'(SeqLen)) begin
                    shreg_d   = shreg_q << 1;
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    out_d     = next_bit;
                    valid_d   = 1'b1;
                    busy_d    = 1'b1;
                end else if (rep_q != '0) begin
                    rep_d  = rep_q - 1'b1;
                    busy_d = 1'b1;
                    if (GAP == 0) begin
                        // Back-to-back: next repetition's MSB follows with no bubble.
                        shreg_d   = pat_q << 1;
                        bit_cnt_d = BitW'(1);
                        out_d     = pat_q[PAT_W-1];
                        valid_d   = 1'b1;
                    end else begin
                        state_d = StGap;
                        gap_d   = GapW'(1);
                    end
                end else begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            StGap: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (gap_q == GapW'(GAP)) begin
                    state_d   = StShift;
                    shreg_d   = pat_q << 1;
                    bit_cnt_d = BitW'(1);
                    out_d     = pat_q[PAT_W-1];
                    valid_d   = 1'b1;
                    busy_d    = 1'b1;
                end else begin
                    gap_d  = gap_q + 1'b1;
                    busy_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            shreg_q   <= '0;
            pat_q     <= '0;
            bit_cnt_q <= '0;
            rep_q     <= '0;
            gap_q     <= '0;
            out_q     <= 1'b0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            pat_q     <= pat_d;
            bit_cnt_q <= bit_cnt_d;
            rep_q     <= rep_d;
            gap_q     <= gap_d;
            out_q     <= out_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign out   = out_q;
    assign valid = valid_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: tb/tb_sequence_generator.sv
// Scoreboard bench for sequence_generator: one GAP=2 instance and one GAP=0 instance,
// each with a queue of per-cycle expected {busy, valid, out, done}.
module tb_sequence_generator;

    localparam int PW = 5;
    localparam int CW = 4;
`ifdef SEQ_GEN_PARITY_EN
    localparam int L = PW + 1;
`else
    localparam int L = PW;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [1:0]    start = '0;
    logic [1:0]    abort = '0;
    logic [PW-1:0] pattern [2];
    logic [CW-1:0] reps [2];
    logic [1:0]    out, valid, busy, done;

    logic [3:0] q0 [$];
    logic [3:0] q1 [$];
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    sequence_generator #(.PAT_W(PW), .CNT_W(CW), .GAP(2)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .pattern(pattern[0]), .reps(reps[0]),
        .abort(abort[0]), .out(out[0]), .valid(valid[0]), .busy(busy[0]), .done(done[0])
    );

    sequence_generator #(.PAT_W(PW), .CNT_W(CW), .GAP(0)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .pattern(pattern[1]), .reps(reps[1]),
        .abort(abort[1]), .out(out[1]), .valid(valid[1]), .busy(busy[1]), .done(done[1])
    );

    task automatic check(input string name, input logic [3:0] got, input logic [3:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s at %0t: {busy,valid,out,done} got %b want %b", name, $time, got,
                     want);
        end
    endtask

    task automatic push(input int d, input logic [3:0] v);
        if (d == 0) q0.push_back(v);
        else q1.push_back(v);
    endtask

    // Expected cycle-by-cycle stream starting the cycle after the start edge.
    // abort_at: index of the cycle that must be idle because abort was sampled; -1 = none.
    task automatic build(input int d, input logic [PW-1:0] pat, input int r, input int abort_at);
        int n = 0;
        int gap = (d == 0) ? 2 : 0;
        logic b;
        for (int rep = 0; rep <= r; rep++) begin
            for (int i = 0; i < L; i++) begin
                if (n == abort_at) begin
                    push(d, 4'b0000);
                    return;
                end
                b = (i < PW) ? pat[PW-1-i] : ^pat;
                push(d, {2'b11, b, 1'b0});
                n++;
            end
            if (rep < r) begin
                for (int g = 0; g < gap; g++) begin
                    if (n == abort_at) begin
                        push(d, 4'b0000);
                        return;
                    end
                    push(d, 4'b1000);
                    n++;
                end
            end
        end
        push(d, 4'b0001);
    endtask

    task automatic go(input int d, input logic [PW-1:0] pat, input logic [CW-1:0] r,
                      input int abort_at);
        pattern[d] = pat;
        reps[d]    = r;
        start[d]   = 1'b1;
        @(posedge clk);
        #1;
        start[d] = 1'b0;
        build(d, pat, int'(r), abort_at);
    endtask

    task automatic wait_done();
        int k = 0;
        while ((q0.size() != 0 || q1.size() != 0) && k < 500) begin
            @(posedge clk);
            k++;
        end
        #1;
        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d/%0d entries left, required 0", q0.size(),
                     q1.size());
            q0.delete();
            q1.delete();
        end
    endtask

    // Monitor: every cycle the DUT must present the queued value, or idle when nothing is queued.
    always @(negedge clk) begin : monitor
        logic [3:0] e0, e1;
        e0 = (q0.size() != 0) ? q0.pop_front() : 4'b0000;
        e1 = (q1.size() != 0) ? q1.pop_front() : 4'b0000;
        check("dut0_stream", {busy[0], valid[0], out[0], done[0]}, e0);
        check("dut1_stream", {busy[1], valid[1], out[1], done[1]}, e1);
    end

    initial begin
        pattern[0] = '0;
        pattern[1] = '0;
        reps[0]    = '0;
        reps[1]    = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Asynchronous reset during the second bit, then a clean sequence.
        go(0, 5'b11011, 0, -1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        q0.delete();
        q1.delete();
        #1 check("async_reset", {busy[0], valid[0], out[0], done[0]}, 4'b0000);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        go(0, 5'b11011, 0, -1);
        wait_done();

        // Single transmission.
        go(0, 5'b01101, 0, -1);
        wait_done();

        // Three copies with gaps; pattern/reps/start changes while busy are ignored.
        go(0, 5'b11010, 2, -1);
        repeat (3) @(posedge clk);
        #1;
        pattern[0] = 5'b00000;
        reps[0]    = 4'd0;
        start[0]   = 1'b1;
        repeat (2) @(posedge clk);
        #1 start[0] = 1'b0;
        wait_done();

        // Abort during the 3rd bit of the 2nd repetition; restart right after.
        go(0, 5'b10011, 3, L + 2 + 3);
        repeat (L + 2 + 2) @(posedge clk);
        #1 abort[0] = 1'b1;
        @(posedge clk);
        #1 abort[0] = 1'b0;
        go(0, 5'b10110, 0, -1);
        wait_done();

        // Abort and start together in idle: nothing starts.
        start[0] = 1'b1;
        abort[0] = 1'b1;
        @(posedge clk);
        #1;
        start[0] = 1'b0;
        abort[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // GAP=0: contiguous repetitions; start held high restarts only after done.
        pattern[1] = 5'b10101;
        reps[1]    = 4'd1;
        start[1]   = 1'b1;
        @(posedge clk);
        #1;
        build(1, 5'b10101, 1, -1);
        build(1, 5'b10101, 1, -1);
        repeat (2 * L + 3) @(posedge clk);
        #1 start[1] = 1'b0;
        wait_done();

        // Maximum reps: 16 back-to-back transmissions.
        go(1, 5'b10010, 4'd15, -1);
        wait_done();

        // Zero-parity pattern with one gap.
        go(0, 5'b11000, 1, -1);
        wait_done();

        repeat (2) @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sequence_generator.md
Name: sequence_generator

Overview:
- Serial pattern transmitter; the source side of the serial bit stream that sequence_detector consumes.
- Captures a parallel PAT_W-bit pattern on a start request and shifts it out MSB-first, one bit per clk.
- Can repeat the pattern with a programmable idle gap, so a detector bench or datapath gets a clean, cycle-exact stimulus stream with busy/done handshaking.

Parameters:
- PAT_W, 5, pattern length in bits (>=2).
- CNT_W, 4, width of the repeat-count input.
- GAP, 2, idle cycles inserted between repetitions (0 allowed = back-to-back).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- pattern  input  PAT_W  bits to send; bit PAT_W-1 goes first.
- reps  input  CNT_W  extra repetitions; total transmissions = reps+1.
- abort  input  1  synchronous cancel.
- out  output  1  serial bit (registered).
- valid  output  1  high when out carries a pattern/parity bit.
- busy  output  1  high while a transfer is in progress.
- done  output  1  one-cycle pulse after the final bit.

Behaviour:
- Reset (rst_n low, any time, including mid-transfer): state IDLE; out=0, valid=0, busy=0, done=0; shift register, bit counter, rep counter and gap counter cleared. All outputs are registered.
- States: IDLE, SHIFT, GAP.
- IDLE:
  - out=0, valid=0, busy=0.
  - start=1 at edge k: capture pattern into shift register, reps into rep counter; go to SHIFT.
  - At edge k: out=pattern[PAT_W-1], valid=1, busy=1.
  - Start is accepted in the same cycle that done is high.
- SHIFT:
  - Each edge shifts left; bits appear at edges k .. k+PAT_W-1.
  - Latency from start sample to first bit on out is 0 cycles after that edge, so first bit is visible during cycle k+1.
- End of a repetition (last bit shown):
  - rep counter > 0 and GAP > 0: next edge -> GAP, out=0, valid=0, busy=1. Rep counter decrements. Shift register reloads from the captured copy, not the live pattern input.
  - rep counter > 0 and GAP = 0: next edge immediately presents the MSB of the next repetition (no bubble).
  - rep counter = 0: next edge -> IDLE, out=0, valid=0, busy=0, done=1 for exactly one cycle.
- GAP: holds exactly GAP cycles, then the next edge presents the MSB (valid=1).
- Input changes: pattern/reps changes during busy are ignored. start during busy is ignored (not queued).
- abort=1 in SHIFT or GAP:
  - Next edge -> IDLE, out=0, valid=0, busy=0.
  - done is NOT pulsed.
  - abort has priority over the end-of-sequence done.
  - abort in IDLE has no effect. abort and start together in IDLE: abort wins, start ignored.
- reps wrap: reps = 2^CNT_W-1 gives 2^CNT_W transmissions; no counter overflow.

Optional Feature:
- Macro SEQ_GEN_PARITY_EN.
- When defined:
  - After the PAT_W pattern bits of every repetition, one extra bit is sent with valid=1.
  - The extra bit is the even parity (XOR) of the captured pattern.
  - Repetition length becomes PAT_W+1; GAP and done timing shift by one cycle accordingly.
- When undefined: no parity bit, no parity logic present.

Test Plan:
- Reset mid-SHIFT: rst_n low during bit 2 -> out=0, valid=0, busy=0 asynchronously. The next start gives a full clean sequence.
- pattern=5'b01101, reps=0, start one cycle:
  - out = 0,1,1,0,1 with valid=1 on 5 consecutive cycles.
  - Then done=1 for one cycle; busy low in that cycle.
- pattern=5'b11010, reps=2, GAP=2:
  - Three copies of 1,1,0,1,0, each separated by exactly 2 cycles of out=0/valid=0.
  - done after the 15th bit.
  - Changing pattern mid-run has no effect.
- abort during the 3rd bit of the 2nd repetition (reps=3) -> idle next edge, done never asserted; start in the following cycle accepted.
- GAP=0 build, reps=1, pattern=5'b10101 -> 10 contiguous valid bits 1010110101; start held high throughout gives a new transfer only after done.
- SEQ_GEN_PARITY_EN defined:
  - pattern=5'b01101 -> 0,1,1,0,1,1 (parity 1).
  - pattern=5'b11000 -> 1,1,0,0,0,0 (parity 0).
  - done one cycle later than the non-parity build.
